crsr_img_mem: RTL and testbench

CRSR_IMG_MEM -- requirements
Module: crsr_img_mem

---
 rtl/crsr_pkg.sv | 31 +++
 rtl/crsr_wfifo.sv | 63 ++++++
 rtl/crsr_img_mem.sv | 104 ++++++++++
 tb/tb_crsr_img_mem.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/crsr_pkg.sv
// Shared types and sizes for the cursor image memory and its write FIFO.
package crsr_pkg;

  localparam int unsigned CRSR_IMG_WORDS   = 256;
  localparam int unsigned CRSR_WFIFO_DEPTH = 4;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } crsr_wr_t;

  localparam int unsigned CRSR_WR_W = $bits(crsr_wr_t);

  typedef enum logic {
    IDLE,
    BURST
  } crsr_burst_e;

  function automatic logic [31:0] crsr_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/crsr_wfifo.sv
// Write-beat FIFO for crsr_img_mem; with CRSR_IMG_FWD_EN it also exposes its
// pending entries oldest-first so the reader can bypass the array.
module crsr_wfifo
  import crsr_pkg::*;
#(
  parameter int unsigned DEPTH = CRSR_WFIFO_DEPTH,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push_i,
  input  logic [CRSR_WR_W-1:0] din_i,
  input  logic                 pop_i,
  output logic [CRSR_WR_W-1:0] dout_o,
  output logic [CW-1:0]        count_o
`ifdef CRSR_IMG_FWD_EN
  ,
  output logic [DEPTH*CRSR_WR_W-1:0] ent_o,
  output logic [DEPTH-1:0]           ent_vld_o
`endif
);

  crsr_wr_t      mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign do_push = push_i && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign wr_d    = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
  assign rd_d    = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_d;
      if (do_pop)  rd_q <= rd_d;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

`ifdef CRSR_IMG_FWD_EN
  always_comb begin
    ent_o     = '0;
    ent_vld_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_o[i*CRSR_WR_W +: CRSR_WR_W] = mem_q[AW'((32'(rd_q) + i) % DEPTH)];
      ent_vld_o[i] = (CW'(i) < cnt_q);
    end
  end
`endif

endmodule

// File: rtl/crsr_img_mem.sv
// Cursor image memory: 256x32 array fed through a 4-deep write FIFO with an
// auto-increment burst pointer. Define CRSR_IMG_FWD_EN to bypass pending writes onto rdata.
module crsr_img_mem
  import crsr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wvalid,
  output logic        wready,
  input  logic [7:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wburst,
  input  logic [7:0]  raddr,
  output logic [31:0] rdata,
  output logic [2:0]  wcount,
  output logic        busy
);

  logic [31:0]          mem_q [CRSR_IMG_WORDS];
  crsr_burst_e          state_q;
  logic [7:0]           ptr_q;
  logic                 push, pop;
  crsr_wr_t             beat, head;
  logic [CRSR_WR_W-1:0] head_bits;
  logic [2:0]           cnt;

  assign wready = (cnt < 3'(CRSR_WFIFO_DEPTH));
  assign push   = wvalid && wready;
  assign pop    = (cnt != '0);
  assign wcount = cnt;
  assign busy   = (cnt != '0) || (state_q != IDLE);
  assign beat   = '{addr: (state_q == BURST) ? ptr_q : waddr, data: wdata, strb: wstrb};
  assign head   = crsr_wr_t'(head_bits);

`ifdef CRSR_IMG_FWD_EN
  logic [CRSR_WFIFO_DEPTH*CRSR_WR_W-1:0] ent;
  logic [CRSR_WFIFO_DEPTH-1:0]           ent_vld;
  crsr_wr_t                              e, fwd;
  logic                                  fwd_hit;
`endif

  crsr_wfifo #(
    .DEPTH(CRSR_WFIFO_DEPTH)
  ) u_wfifo (
    .clk      (clk),
    .reset    (reset),
    .push_i   (push),
    .din_i    (beat),
    .pop_i    (pop),
    .dout_o   (head_bits),
    .count_o  (cnt)
`ifdef CRSR_IMG_FWD_EN
    ,
    .ent_o    (ent),
    .ent_vld_o(ent_vld)
`endif
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else if (push) begin
      case (state_q)
        IDLE: begin
          if (wburst) begin
            ptr_q   <= waddr + 8'd1;
            state_q <= BURST;
          end
        end
        BURST: begin
          ptr_q <= ptr_q + 8'd1;
          if (!wburst) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Array is intentionally unreset; reset only gates the write enable.
  always_ff @(posedge clk) begin
    if (pop && !reset) mem_q[head.addr] <= crsr_merge(mem_q[head.addr], head.data, head.strb);
  end

  always_comb begin
    rdata = mem_q[raddr];
`ifdef CRSR_IMG_FWD_EN
    fwd_hit = 1'b0;
    fwd     = '0;
    e       = '0;
    // Entries are ordered oldest-first, so the last match is the newest.
    for (int unsigned i = 0; i < CRSR_WFIFO_DEPTH; i++) begin
      e = crsr_wr_t'(ent[i*CRSR_WR_W +: CRSR_WR_W]);
      if (ent_vld[i] && (e.addr == raddr)) begin
        fwd_hit = 1'b1;
        fwd     = e;
      end
    end
    if (fwd_hit) rdata = crsr_merge(rdata, fwd.data, fwd.strb);
`endif
  end

endmodule

// File: tb/tb_crsr_img_mem.sv
// Scoreboard bench for crsr_img_mem (default build or with CRSR_IMG_FWD_EN).
module tb_crsr_img_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        wvalid;
  logic        wready;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wburst;
  logic [7:0]  raddr;
  logic [31:0] rdata;
  logic [2:0]  wcount;
  logic        busy;

  crsr_img_mem dut (
    .clk   (clk),
    .reset (reset),
    .wvalid(wvalid),
    .wready(wready),
    .waddr (waddr),
    .wdata (wdata),
    .wstrb (wstrb),
    .wburst(wburst),
    .raddr (raddr),
    .rdata (rdata),
    .wcount(wcount),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] mdl [256];
  logic        m_burst;
  logic [7:0]  m_ptr;
  int          n_chk  = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Drive one beat, wait (bounded) for acceptance, update model and scoreboard.
  task automatic send(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic b);
    logic [7:0] ea;
    int t;
    wvalid = 1'b1; waddr = a; wdata = d; wstrb = s; wburst = b;
    t = 0;
    while (!wready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!wready) begin
      check_eq("accept_timeout", 32'(wready), 32'd1);
      wvalid = 1'b0;
    end else begin
      ea = m_burst ? m_ptr : a;
      if (m_burst) begin
        m_ptr = m_ptr + 8'd1;
        if (!b) m_burst = 1'b0;
      end else if (b) begin
        m_ptr   = a + 8'd1;
        m_burst = 1'b1;
      end
      mdl[ea] = byte_merge(mdl[ea], d, s);
      sb.push_back('{a: ea, d: mdl[ea]});
      @(posedge clk); #1;
      wvalid = 1'b0;
    end
  endtask

  task automatic drain_and_check(input string tag);
    sb_t e;
    int t;
    wvalid = 1'b0;
    t = 0;
    while (busy && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      raddr = e.a;
      #1;
      check_eq({tag, "_rd"}, rdata, e.d);
    end
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    raddr = a;
    #1;
    check_eq(tag, rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; wvalid = 1'b0; waddr = '0; wdata = '0; wstrb = '0; wburst = 1'b0;
    raddr = '0; m_burst = 1'b0; m_ptr = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wcount", 32'(wcount), 32'd0);
    check_eq("rst_wready", 32'(wready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single beat latency
    raddr = 8'h10;
    send(8'h10, 32'hA5A5A5A5, 4'hF, 1'b0);
    check_eq("single_cnt1", 32'(wcount), 32'd1);
    @(posedge clk); #1;
    check_eq("single_vis", rdata, 32'hA5A5A5A5);
    check_eq("single_cnt0", 32'(wcount), 32'd0);
    drain_and_check("single");

    // Byte strobes
    send(8'h20, 32'h11223344, 4'hF, 1'b0);
    drain_and_check("pre20");
    send(8'h20, 32'hFFFFFFFF, 4'h5, 1'b0);
    drain_and_check("strb");
    read_chk("strb_const", 8'h20, 32'h11FF33FF);

    // Burst wrapping 0xFF -> 0x00, waddr ignored mid-burst
    send(8'hFE, 32'd1, 4'hF, 1'b1);
    send(8'h55, 32'd2, 4'hF, 1'b1);
    send(8'h66, 32'd3, 4'hF, 1'b0);
    drain_and_check("burst");
    read_chk("burst_fe", 8'hFE, 32'd1);
    read_chk("burst_ff", 8'hFF, 32'd2);
    read_chk("burst_00", 8'h00, 32'd3);
    send(8'h70, 32'h77, 4'hF, 1'b0);
    drain_and_check("post_burst");
    read_chk("post_burst_70", 8'h70, 32'h77);

    // Backpressure with draining held off
    force dut.pop = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(8'h80 + i), 32'hB000_0000 + i, 4'hF, 1'b0);
    check_eq("bp_full_cnt", 32'(wcount), 32'd4);
    check_eq("bp_wready", 32'(wready), 32'd0);
    wvalid = 1'b1; waddr = 8'h84; wdata = 32'hB000_0004; wstrb = 4'hF; wburst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("bp_hold_cnt", 32'(wcount), 32'd4);
    release dut.pop;
    send(8'h84, 32'hB000_0004, 4'hF, 1'b0);
    send(8'h85, 32'hB000_0005, 4'hF, 1'b0);
    drain_and_check("bp");

    // Reset in the middle of a burst with two entries pending
    send(8'h40, 32'h40404040, 4'hF, 1'b0);
    send(8'h41, 32'h41414141, 4'hF, 1'b0);
    drain_and_check("pre40");
    force dut.pop = 1'b0;
    send(8'h40, 32'hC1, 4'hF, 1'b1);
    send(8'h99, 32'hC2, 4'hF, 1'b1);
    check_eq("mid_cnt", 32'(wcount), 32'd2);
    reset = 1'b1;
    #2;
    check_eq("mid_rst_cnt", 32'(wcount), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_wready", 32'(wready), 32'd1);
    release dut.pop;
    sb.delete();
    mdl[8'h40] = 32'h40404040;
    mdl[8'h41] = 32'h41414141;
    m_burst = 1'b0;
    m_ptr = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    read_chk("mid_keep40", 8'h40, 32'h40404040);
    read_chk("mid_keep41", 8'h41, 32'h41414141);
    send(8'h50, 32'h5050AAAA, 4'hF, 1'b0);
    drain_and_check("mid_next");
    read_chk("mid_next_50", 8'h50, 32'h5050AAAA);
    read_chk("mid_keep42_40", 8'h40, 32'h40404040);

    // Read-during-write on the same address
    send(8'h30, 32'h12345678, 4'hF, 1'b0);
    drain_and_check("pre30");
    raddr = 8'h30;
    send(8'h30, 32'hDEADBEEF, 4'hF, 1'b0);
`ifdef CRSR_IMG_FWD_EN
    check_eq("fwd_bypass", rdata, 32'hDEADBEEF);
`else
    check_eq("fwd_old", rdata, 32'h12345678);
`endif
    @(posedge clk); #1;
    check_eq("fwd_after", rdata, 32'hDEADBEEF);
    drain_and_check("fwd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
